kb_scan_ctrl: RTL and testbench
===============================

Name: kb_scan_ctrl

Overview:
Sequencing controller between the PS/2 receive FIFO and the scancode-to-ASCII lookup ROM.
- Pops scancode bytes from the FIFO and parses make, break (F0) and extended (E0) prefixes.
- Drives the lookup address and captures the ASCII result.
- Tracks key-down state, modifier keys and a press counter for the display logic.

Parameters:
CNT_W, 8, width of the key press counter (wraps modulo 2^CNT_W)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
ready  in  1  FIFO non-empty; data valid
data  in  8  FIFO head byte
nextdata_n  out  1  active-low FIFO pop strobe, low exactly one cycle per byte
kbcode  out  8  registered address to lookup ROM
asciicode  in  8  lookup ROM result (combinational, valid same cycle as kbcode)
key_down  out  1  a non-modifier key is currently held
cur_scan  out  8  scancode of most recent non-modifier make
cur_ascii  out  8  ASCII of cur_scan (0x00 for extended keys)
ascii_valid  out  1  one-cycle pulse when cur_ascii updates on a new press
key_count  out  CNT_W  count of new non-modifier presses
shift_on  out  1  left (0x12) or right (0x59) shift held
caps_on  out  1  caps-lock toggle state

Behaviour:
- Clock and reset: single clock clk; rst synchronous, active-high. On reset, all outputs are 0, nextdata_n is 1, state is IDLE, and internal brk/ext/caps_held flags are 0.
- FSM states: IDLE, POP, CLASSIFY, LOOKUP.
- IDLE: if ready, latch data into byte_r, drive nextdata_n to 0 (registered), go to POP. Otherwise stay.
- POP: nextdata_n is 0 this cycle; ready is not sampled; go to CLASSIFY.
- CLASSIFY (nextdata_n back to 1):
  - byte_r==F0: set brk, go to IDLE.
  - byte_r==E0: set ext, go to IDLE.
  - brk set (release):
    - 0x12/0x59: shift_on<=0.
    - 0x58: caps_held<=0.
    - byte_r==cur_scan: key_down<=0.
    - Any other code is ignored.
    - Clear brk and ext, go to IDLE.
  - Make of 0x12/0x59 (ext clear): shift_on<=1, go to IDLE.
  - Make of 0x58: if !caps_held then toggle caps_on and set caps_held; go to IDLE. Modifiers are never counted and never change cur_scan.
  - Make with key_down && byte_r==cur_scan (typematic repeat): no count, no pulse; clear ext; go to IDLE.
  - Other make (new key, including rollover onto a different key): kbcode<=byte_r, go to LOOKUP.
- LOOKUP:
  - Updates: cur_scan<=kbcode; key_down<=1; key_count<=key_count+1 (wraps); ascii_valid<=1 for one cycle.
  - cur_ascii<=0x00 if ext, else asciicode (case-adjusted per optional feature).
  - Clear ext, go to IDLE.
- Latency: ready sampled at cycle 0 → nextdata_n low in cycle 1 → ascii_valid high in cycle 4.
- FIFO handling: at most one byte is consumed per 4-cycle pass. A FIFO that is empty while in POP cannot occur, since ready was sampled in IDLE.
- Reset mid-operation: in any state, reset returns the block to IDLE and clears all registers. Any partially parsed prefix is discarded.

Optional Feature:
KB_SHIFT_CASE_EN
- Defined: in LOOKUP, when asciicode is in 0x61–0x7A and (shift_on XOR caps_on), cur_ascii = asciicode − 0x20.
- Undefined: cur_ascii = asciicode unchanged; shift_on and caps_on are still tracked and output.

Decomposition:
- Shared include kb_defs.vh holds:
  - Scancode constants: KB_BRK=8'hF0, KB_EXT=8'hE0, KB_LSHIFT=8'h12, KB_RSHIFT=8'h59, KB_CAPS=8'h58.
  - FSM state encodings (2-bit).
- One combinational sub-module, kb_case_fix (asciicode, shift_on, caps_on → adjusted ASCII), instantiated only under KB_SHIFT_CASE_EN.
- The lookup ROM is instantiated beside this block, not inside it.

Test Plan:
1. Push 0x1C (ROM→0x61) → nextdata_n low in cycle 1 only; ascii_valid pulse in cycle 4; cur_scan=0x1C, cur_ascii=0x61, key_down=1, key_count=1.
2. Push 1C,1C,1C then F0,1C → key_count stays 1; one ascii_valid pulse total; key_down=0 after release; cur_scan stays 0x1C.
3. Push 12,1C,F0,1C,F0,12 → with macro cur_ascii=0x41, without 0x61; shift_on 1 then 0; key_count=1.
4. Push 58,58,F0,58,58,F0,58 → caps_on 1 after the first 58, unchanged on the repeat, 0 after the third 58; key_count=0.
5. Push E0,75 then E0,F0,75 → cur_ascii=0x00, key_down=1, key_count+1; then key_down=0.
6. Preload key_count=255 via 255 distinct presses, press 0x1C → key_count=0. Separately, assert rst during POP → next cycle nextdata_n=1, state IDLE, all outputs 0.

Source files
------------

// File: rtl/kb_scan_ctrl_pkg.sv
// Shared scancode constants, FSM state encoding and small decode helpers for
// the PS/2 scan controller.
package kb_scan_ctrl_pkg;

  localparam logic [7:0] KB_BRK    = 8'hF0;
  localparam logic [7:0] KB_EXT    = 8'hE0;
  localparam logic [7:0] KB_LSHIFT = 8'h12;
  localparam logic [7:0] KB_RSHIFT = 8'h59;
  localparam logic [7:0] KB_CAPS   = 8'h58;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_POP      = 2'b01,
    ST_CLASSIFY = 2'b10,
    ST_LOOKUP   = 2'b11
  } kb_state_e;

  function automatic logic is_shift(input logic [7:0] code);
    return (code == KB_LSHIFT) || (code == KB_RSHIFT);
  endfunction

  function automatic logic is_lower(input logic [7:0] ch);
    return (ch >= 8'h61) && (ch <= 8'h7A);
  endfunction

endpackage

// File: rtl/kb_case_fix.sv
// Shift/caps case adjustment of the lookup ROM result: lowercase letters become
// uppercase when exactly one of shift or caps-lock is active.
module kb_case_fix
  import kb_scan_ctrl_pkg::*;
(
  input  logic [7:0] asciicode,
  input  logic       shift_on,
  input  logic       caps_on,
  output logic [7:0] ascii_out
);

  always_comb begin
    ascii_out = asciicode;
    if (is_lower(asciicode) && (shift_on ^ caps_on)) begin
      ascii_out = asciicode - 8'h20;
    end
  end

endmodule

// File: rtl/kb_scan_ctrl.sv
// Sequencer between the PS/2 receive FIFO and the scancode-to-ASCII ROM.
// Optional case adjustment of letters is enabled by defining KB_SHIFT_CASE_EN.
module kb_scan_ctrl
  import kb_scan_ctrl_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ready,
  input  logic [7:0]       data,
  output logic             nextdata_n,
  output logic [7:0]       kbcode,
  input  logic [7:0]       asciicode,
  output logic             key_down,
  output logic [7:0]       cur_scan,
  output logic [7:0]       cur_ascii,
  output logic             ascii_valid,
  output logic [CNT_W-1:0] key_count,
  output logic             shift_on,
  output logic             caps_on
);

  kb_state_e        state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic             nextdata_n_q, nextdata_n_d;
  logic [7:0]       kbcode_q, kbcode_d;
  logic             key_down_q, key_down_d;
  logic [7:0]       cur_scan_q, cur_scan_d;
  logic [7:0]       cur_ascii_q, cur_ascii_d;
  logic             ascii_valid_q, ascii_valid_d;
  logic [CNT_W-1:0] key_count_q, key_count_d;
  logic             shift_q, shift_d;
  logic             caps_q, caps_d;
  logic             caps_held_q, caps_held_d;
  logic             brk_q, brk_d;
  logic             ext_q, ext_d;
  logic [7:0]       lookup_ascii;

`ifdef KB_SHIFT_CASE_EN
  kb_case_fix u_case_fix (
    .asciicode (asciicode),
    .shift_on  (shift_q),
    .caps_on   (caps_q),
    .ascii_out (lookup_ascii)
  );
`else
  assign lookup_ascii = asciicode;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      byte_q        <= 8'h00;
      nextdata_n_q  <= 1'b1;
      kbcode_q      <= 8'h00;
      key_down_q    <= 1'b0;
      cur_scan_q    <= 8'h00;
      cur_ascii_q   <= 8'h00;
      ascii_valid_q <= 1'b0;
      key_count_q   <= '0;
      shift_q       <= 1'b0;
      caps_q        <= 1'b0;
      caps_held_q   <= 1'b0;
      brk_q         <= 1'b0;
      ext_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_q        <= byte_d;
      nextdata_n_q  <= nextdata_n_d;
      kbcode_q      <= kbcode_d;
      key_down_q    <= key_down_d;
      cur_scan_q    <= cur_scan_d;
      cur_ascii_q   <= cur_ascii_d;
      ascii_valid_q <= ascii_valid_d;
      key_count_q   <= key_count_d;
      shift_q       <= shift_d;
      caps_q        <= caps_d;
      caps_held_q   <= caps_held_d;
      brk_q         <= brk_d;
      ext_q         <= ext_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    byte_d        = byte_q;
    nextdata_n_d  = 1'b1;
    kbcode_d      = kbcode_q;
    key_down_d    = key_down_q;
    cur_scan_d    = cur_scan_q;
    cur_ascii_d   = cur_ascii_q;
    ascii_valid_d = 1'b0;
    key_count_d   = key_count_q;
    shift_d       = shift_q;
    caps_d        = caps_q;
    caps_held_d   = caps_held_q;
    brk_d         = brk_q;
    ext_d         = ext_q;

    case (state_q)
      ST_IDLE: begin
        if (ready) begin
          byte_d       = data;
          nextdata_n_d = 1'b0;
          state_d      = ST_POP;
        end
      end

      ST_POP: begin
        state_d = ST_CLASSIFY;
      end

      ST_CLASSIFY: begin
        state_d = ST_IDLE;
        if (byte_q == KB_BRK) begin
          brk_d = 1'b1;
        end else if (byte_q == KB_EXT) begin
          ext_d = 1'b1;
        end else if (brk_q) begin
          // Release: each check is independent; unmatched codes fall through.
          if (is_shift(byte_q)) shift_d = 1'b0;
          if (byte_q == KB_CAPS) caps_held_d = 1'b0;
          if (byte_q == cur_scan_q) key_down_d = 1'b0;
          brk_d = 1'b0;
          ext_d = 1'b0;
        end else begin
          ext_d = 1'b0;
          if (is_shift(byte_q) && !ext_q) begin
            shift_d = 1'b1;
          end else if (byte_q == KB_CAPS) begin
            // caps_held blocks typematic repeats from re-toggling the lock.
            if (!caps_held_q) begin
              caps_d      = ~caps_q;
              caps_held_d = 1'b1;
            end
          end else if (key_down_q && (byte_q == cur_scan_q)) begin
            ext_d = 1'b0;
          end else begin
            kbcode_d = byte_q;
            ext_d    = ext_q;
            state_d  = ST_LOOKUP;
          end
        end
      end

      ST_LOOKUP: begin
        cur_scan_d    = kbcode_q;
        key_down_d    = 1'b1;
        key_count_d   = key_count_q + CNT_W'(1);
        ascii_valid_d = 1'b1;
        cur_ascii_d   = ext_q ? 8'h00 : lookup_ascii;
        ext_d         = 1'b0;
        state_d       = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign nextdata_n  = nextdata_n_q;
  assign kbcode      = kbcode_q;
  assign key_down    = key_down_q;
  assign cur_scan    = cur_scan_q;
  assign cur_ascii   = cur_ascii_q;
  assign ascii_valid = ascii_valid_q;
  assign key_count   = key_count_q;
  assign shift_on    = shift_q;
  assign caps_on     = caps_q;

endmodule

// File: tb/tb_kb_scan_ctrl.sv
// Directed bench for kb_scan_ctrl: a queue models the PS/2 FIFO and a small
// function models the lookup ROM beside the controller.
module tb_kb_scan_ctrl;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ready = 1'b0;
  logic [7:0]       data = 8'h00;
  logic             nextdata_n;
  logic [7:0]       kbcode;
  logic [7:0]       asciicode;
  logic             key_down;
  logic [7:0]       cur_scan;
  logic [7:0]       cur_ascii;
  logic             ascii_valid;
  logic [CNT_W-1:0] key_count;
  logic             shift_on;
  logic             caps_on;

  logic [7:0] fifo[$];
  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;
  int pops = 0;

  kb_scan_ctrl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .ready       (ready),
    .data        (data),
    .nextdata_n  (nextdata_n),
    .kbcode      (kbcode),
    .asciicode   (asciicode),
    .key_down    (key_down),
    .cur_scan    (cur_scan),
    .cur_ascii   (cur_ascii),
    .ascii_valid (ascii_valid),
    .key_count   (key_count),
    .shift_on    (shift_on),
    .caps_on     (caps_on)
  );

  function automatic logic [7:0] rom(input logic [7:0] code);
    case (code)
      8'h1C:   return 8'h61;
      8'h75:   return 8'h38;
      8'h15:   return 8'h71;
      8'h1D:   return 8'h77;
      default: return 8'h3F;
    endcase
  endfunction

  assign asciicode = rom(kbcode);

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!nextdata_n && fifo.size() > 0) void'(fifo.pop_front());
  end

  always @(negedge clk) begin
    ready = (fifo.size() != 0);
    data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    if (ascii_valid) pulses++;
    if (!nextdata_n) pops++;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-14s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic feed(input logic [7:0] b);
    fifo.push_back(b);
    cyc(6);
    check("fifo_drained", 32'(fifo.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    fifo.delete();
    pulses = 0;
    pops = 0;
  endtask

  logic [7:0] exp_ascii;

  initial begin
    cyc(3);
    check("rst_nextdata_n", 32'(nextdata_n), 32'd1);
    check("rst_kbcode", 32'(kbcode), 32'd0);
    check("rst_outputs", {key_down, ascii_valid, shift_on, caps_on}, 32'd0);
    check("rst_regs", {cur_scan, cur_ascii, key_count}, 32'd0);
    rst = 1'b0;
    pulses = 0;
    pops = 0;

    // Single press: exact pop strobe and result latency.
    do_reset();
    fifo.push_back(8'h1C);
    cyc(1); check("t1_nd_c0", 32'(nextdata_n), 32'd1);
    cyc(1); check("t1_nd_c1", 32'(nextdata_n), 32'd0);
    cyc(1); check("t1_nd_c2", 32'(nextdata_n), 32'd1);
            check("t1_av_c2", 32'(ascii_valid), 32'd0);
    cyc(1); check("t1_av_c3", 32'(ascii_valid), 32'd0);
            check("t1_kbcode", 32'(kbcode), 32'h1C);
    cyc(1); check("t1_av_c4", 32'(ascii_valid), 32'd1);
            check("t1_scan", 32'(cur_scan), 32'h1C);
            check("t1_ascii", 32'(cur_ascii), 32'h61);
            check("t1_down", 32'(key_down), 32'd1);
            check("t1_count", 32'(key_count), 32'd1);
    cyc(1); check("t1_av_c5", 32'(ascii_valid), 32'd0);
            check("t1_pops", 32'(pops), 32'd1);

    // Typematic repeats then release.
    do_reset();
    feed(8'h1C); feed(8'h1C); feed(8'h1C);
    check("t2_count_rep", 32'(key_count), 32'd1);
    check("t2_down_rep", 32'(key_down), 32'd1);
    feed(8'hF0); feed(8'h1C);
    check("t2_count", 32'(key_count), 32'd1);
    check("t2_pulses", 32'(pulses), 32'd1);
    check("t2_down_rel", 32'(key_down), 32'd0);
    check("t2_scan", 32'(cur_scan), 32'h1C);

    // Shifted letter.
    do_reset();
    feed(8'h12);
    check("t3_shift_on", 32'(shift_on), 32'd1);
    feed(8'h1C);
`ifdef KB_SHIFT_CASE_EN
    exp_ascii = 8'h41;
`else
    exp_ascii = 8'h61;
`endif
    check("t3_ascii", 32'(cur_ascii), 32'(exp_ascii));
    feed(8'hF0); feed(8'h1C);
    check("t3_shift_hold", 32'(shift_on), 32'd1);
    feed(8'hF0); feed(8'h12);
    check("t3_shift_off", 32'(shift_on), 32'd0);
    check("t3_count", 32'(key_count), 32'd1);

    // Caps-lock toggle with held-key suppression.
    do_reset();
    feed(8'h58);
    check("t4_caps_1", 32'(caps_on), 32'd1);
    feed(8'h58);
    check("t4_caps_rep", 32'(caps_on), 32'd1);
    feed(8'hF0); feed(8'h58);
    check("t4_caps_rel", 32'(caps_on), 32'd1);
    feed(8'h58);
    check("t4_caps_0", 32'(caps_on), 32'd0);
    feed(8'hF0); feed(8'h58);
    check("t4_count", 32'(key_count), 32'd0);
    check("t4_pulses", 32'(pulses), 32'd0);
    check("t4_scan", 32'(cur_scan), 32'd0);

    // Extended key press and release.
    do_reset();
    feed(8'hE0); feed(8'h75);
    check("t5_ascii", 32'(cur_ascii), 32'd0);
    check("t5_scan", 32'(cur_scan), 32'h75);
    check("t5_down", 32'(key_down), 32'd1);
    check("t5_count", 32'(key_count), 32'd1);
    feed(8'hE0); feed(8'hF0); feed(8'h75);
    check("t5_down_rel", 32'(key_down), 32'd0);
    check("t5_count_rel", 32'(key_count), 32'd1);

    // Counter wrap after 256 new presses.
    do_reset();
    for (int i = 0; i < 255; i++) feed((i % 2 == 0) ? 8'h15 : 8'h1D);
    check("t6_count_255", 32'(key_count), 32'd255);
    check("t6_ascii_last", 32'(cur_ascii), 32'h71);
    feed(8'h1C);
    check("t6_count_wrap", 32'(key_count), 32'd0);
    check("t6_ascii", 32'(cur_ascii), 32'h61);

    // Reset asserted while in POP.
    do_reset();
    feed(8'h58);
    feed(8'h12);
    fifo.push_back(8'h1C);
    cyc(2);
    check("t7_nd_pop", 32'(nextdata_n), 32'd0);
    rst = 1'b1;
    cyc(1);
    check("t7_nd_rst", 32'(nextdata_n), 32'd1);
    check("t7_outs", {key_down, ascii_valid, shift_on, caps_on}, 32'd0);
    check("t7_regs", {kbcode, cur_scan, cur_ascii, key_count}, 32'd0);
    rst = 1'b0;
    pops = 0;
    pulses = 0;
    cyc(6);
    check("t7_idle_pops", 32'(pops), 32'd0);
    check("t7_idle_pulse", 32'(pulses), 32'd0);
    check("t7_idle_count", 32'(key_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
